// File: rtl/run_detect_ctrl.sv
// run_detect_ctrl: programmable run-length detector; counts bits that extend a run to >= cfg_len
//   clk, rst      : clock, synchronous active-high reset
//   start, abort  : begin with latched config (IDLE only) / return to IDLE from any state
//   cfg_len/mode/target : run length, polarity enables (bit0=1s, bit1=0s), events until done
//   bit_vld, bit_in : qualified serial bit stream
//   busy, hit, done, err : status; hit/done/err are one-cycle pulses
//   evt_cnt, run_len : event count since last accepted start, current saturating run length
module run_detect_ctrl #(
    parameter int CNT_W = 4,
    parameter int EVT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_len,
    input  logic [1:0]       cfg_mode,
    input  logic [EVT_W-1:0] cfg_target,
    input  logic             bit_vld,
    input  logic             bit_in,
    output logic             busy,
    output logic             hit,
    output logic             done,
    output logic             err,
    output logic [EVT_W-1:0] evt_cnt,
    output logic [CNT_W-1:0] run_len
);
    typedef enum logic [1:0] {IDLE, FIRST, RUN, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [1:0]       mode_q;
    logic [EVT_W-1:0] tgt_q;
    logic             last_bit;
    logic [CNT_W-1:0] len_nxt;
    logic [EVT_W-1:0] evt_nxt;
    logic             match;
    logic             bad_cfg;
    always_comb begin
        len_nxt = (bit_in != last_bit) ? CNT_W'(1) : (&run_len) ? run_len : run_len + CNT_W'(1);
        match   = (len_nxt >= len_q) && (bit_in ? mode_q[0] : mode_q[1]);
        evt_nxt = evt_cnt + EVT_W'(1);
        bad_cfg = (cfg_len < CNT_W'(2)) || (cfg_mode == 2'd0) || (cfg_target == '0);
    end
    assign busy = (state != IDLE);
    assign done = (state == DONE);
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hit      <= 1'b0;
            err      <= 1'b0;
            evt_cnt  <= '0;
            run_len  <= '0;
            last_bit <= 1'b0;
            len_q    <= '0;
            mode_q   <= '0;
            tgt_q    <= '0;
        end else begin
            hit <= 1'b0;
            err <= 1'b0;
            // abort suppresses start, hit and done for this edge; counters hold
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && bad_cfg) begin
                            err <= 1'b1;
                        end else if (start) begin
                            len_q   <= cfg_len;
                            mode_q  <= cfg_mode;
                            tgt_q   <= cfg_target;
                            evt_cnt <= '0;
                            run_len <= '0;
                            state   <= FIRST;
                        end
                    end
                    FIRST: begin
                        if (bit_vld) begin
                            last_bit <= bit_in;
                            run_len  <= CNT_W'(1);
                            state    <= RUN;
                        end
                    end
                    RUN: begin
                        if (bit_vld) begin
                            last_bit <= bit_in;
                            run_len  <= len_nxt;
                            if (match) begin
                                hit     <= 1'b1;
                                evt_cnt <= evt_nxt;
                                state   <= (evt_nxt == tgt_q) ? DONE : RUN;
                            end
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_run_detect_ctrl.sv
// tb_run_detect_ctrl: scoreboard bench for run_detect_ctrl against a behavioural model
module tb_run_detect_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] cfg_len = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_target = '0;
    logic       bit_vld = 1'b0;
    logic       bit_in = 1'b0;
    logic       busy, hit, done, err;
    logic [7:0] evt_cnt;
    logic [3:0] run_len;
    run_detect_ctrl #(.CNT_W(4), .EVT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_len(cfg_len), .cfg_mode(cfg_mode), .cfg_target(cfg_target),
        .bit_vld(bit_vld), .bit_in(bit_in),
        .busy(busy), .hit(hit), .done(done), .err(err),
        .evt_cnt(evt_cnt), .run_len(run_len)
    );
    always #5 clk = ~clk;
    typedef struct {
        int h;
        int d;
        int e;
        int b;
        int ev;
        int rl;
    } exp_t;
    exp_t q[$];
    int total = 0;
    int bad = 0;
    int hits = 0;
    int errs = 0;
    int ms = 0;
    int ml = 0;
    int mm = 0;
    int mt = 0;
    int me = 0;
    int mr = 0;
    int mlast = 0;
    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask
    task automatic compare();
        exp_t x;
        x = q.pop_front();
        chk("hit", int'(hit), x.h);
        chk("done", int'(done), x.d);
        chk("err", int'(err), x.e);
        chk("busy", int'(busy), x.b);
        chk("evt_cnt", int'(evt_cnt), x.ev);
        chk("run_len", int'(run_len), x.rl);
        hits += int'(hit);
        errs += int'(err);
    endtask
    task automatic cyc(input int st, input int l, input int m, input int t, input int v, input int b, input int ab);
        exp_t x;
        int eh;
        int ee;
        eh = 0;
        ee = 0;
        if (ab != 0) begin
            ms = 0;
        end else if (ms == 0) begin
            if (st != 0 && (l < 2 || m == 0 || t == 0)) begin
                ee = 1;
            end else if (st != 0) begin
                ml = l; mm = m; mt = t; me = 0; mr = 0; ms = 1;
            end
        end else if (ms == 1) begin
            if (v != 0) begin
                mlast = b; mr = 1; ms = 2;
            end
        end else if (ms == 2) begin
            if (v != 0) begin
                mr = (b == mlast) ? ((mr < 15) ? mr + 1 : 15) : 1;
                mlast = b;
                if (mr >= ml && ((b != 0) ? (mm & 1) != 0 : (mm & 2) != 0)) begin
                    eh = 1;
                    me++;
                    if (me == mt) ms = 3;
                end
            end
        end else begin
            ms = 0;
        end
        x = '{eh, int'(ms == 3), ee, int'(ms != 0), me, mr};
        q.push_back(x);
        start = 1'(st);
        cfg_len = 4'(l);
        cfg_mode = 2'(m);
        cfg_target = 8'(t);
        bit_vld = 1'(v);
        bit_in = 1'(b);
        abort = 1'(ab);
        @(posedge clk);
        #1;
        compare();
    endtask
    task automatic go(input int l, input int m, input int t);
        cyc(1, l, m, t, 0, 0, 0);
    endtask
    task automatic bit_(input int v, input int b);
        cyc(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), v, b, 0);
    endtask
    task automatic do_rst();
        exp_t x;
        ms = 0; me = 0; mr = 0; mlast = 0;
        x = '{0, 0, 0, 0, 0, 0};
        q.push_back(x);
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        bit_vld = 1'b1;
        bit_in = 1'b1;
        @(posedge clk);
        #1;
        compare();
        rst = 1'b0;
    endtask
    initial begin
        int pat1[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        int pat2[6] = '{0, 0, 0, 1, 1, 1};
        do_rst();
        do_rst();
        bit_(1, 1);
        bit_(1, 1);
        hits = 0;
        go(3, 3, 4);
        foreach (pat1[i]) bit_(1, pat1[i]);
        chk("t1_done_busy", int'(busy), 1);
        bit_(0, 0);
        chk("t1_hits", hits, 4);
        chk("t1_evt", int'(evt_cnt), 4);
        chk("t1_idle", int'(busy), 0);
        hits = 0;
        go(2, 1, 2);
        foreach (pat2[i]) bit_(1, pat2[i]);
        bit_(0, 0);
        chk("t2_hits", hits, 2);
        hits = 0;
        go(15, 2, 3);
        for (int i = 0; i < 17; i++) begin
            bit_(1, 0);
            bit_(0, 1);
        end
        chk("t3_hits", hits, 3);
        chk("t3_sat", int'(run_len), 15);
        chk("t3_evt", int'(evt_cnt), 3);
        errs = 0;
        go(1, 3, 5);
        go(3, 0, 5);
        go(3, 3, 0);
        bit_(0, 0);
        chk("t4_errs", errs, 3);
        chk("t4_evt_held", int'(evt_cnt), 3);
        hits = 0;
        go(3, 3, 5);
        for (int i = 0; i < 4; i++) bit_(1, 1);
        cyc(0, 3, 3, 5, 1, 1, 1);
        bit_(1, 1);
        chk("t5_hits", hits, 2);
        chk("t5_evt_held", int'(evt_cnt), 2);
        chk("t5_idle", int'(busy), 0);
        go(4, 1, 1);
        chk("t5_evt_clr", int'(evt_cnt), 0);
        cyc(1, 2, 3, 1, 0, 0, 0);
        hits = 0;
        for (int i = 0; i < 3; i++) bit_(1, 1);
        chk("t5_cfg_kept", hits, 0);
        bit_(1, 1);
        chk("t5_done", int'(done), 1);
        bit_(0, 0);
        go(2, 3, 9);
        for (int i = 0; i < 3; i++) bit_(1, 1);
        do_rst();
        bit_(1, 1);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/run_detect_ctrl.md
# run_detect_ctrl

Programmable run-length detection controller for the serial-bit datapath. It is started with a configuration: run length, polarity mode and a target event count. It then consumes a qualified bit stream and flags every bit that extends a run of identical bits to at least the programmed length. Overlapping runs count. It counts these events and signals completion when the target is reached. It generalises the fixed 000/111 detector into a sequenced, abortable, software-configured unit.

## Interface
- CNT_W, 4: width of the run-length counter and of `cfg_len`.
- EVT_W, 8: width of the event counter and of `cfg_target`.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to latch config and begin; ignored unless IDLE.
- abort  in  1  return to IDLE from any state; wins over start and bit_vld.
- cfg_len  in  CNT_W  required run length; legal 2..2^CNT_W-1.
- cfg_mode  in  2  bit0 = detect runs of 1s, bit1 = detect runs of 0s; legal 1..3.
- cfg_target  in  EVT_W  events until done; legal 1..2^EVT_W-1.
- bit_vld  in  1  bit_in is valid this cycle.
- bit_in  in  1  serial data bit.
- busy  out  1  high in FIRST, RUN and DONE.
- hit  out  1  one-cycle pulse per detected event.
- done  out  1  one-cycle pulse when evt_cnt reaches the target.
- err  out  1  one-cycle pulse when start is seen with an illegal config.
- evt_cnt  out  EVT_W  events counted since last accepted start; holds after done/abort.
- run_len  out  CNT_W  current run length, saturating.

## Operation
- States: IDLE, FIRST, RUN, DONE. All registers are updated on the rising clock edge.
- **IDLE**
  - start with legal config: latch cfg_len, cfg_mode, cfg_target. Clear evt_cnt and run_len. Go to FIRST.
  - start with illegal config (cfg_len<2, cfg_mode==0 or cfg_target==0): stay in IDLE, err=1 next cycle, counters unchanged.
  - bit_vld is ignored.
- **FIRST** (no history): on bit_vld, set last_bit=bit_in, run_len=1, go to RUN. No hit is possible here.
- **RUN**: on bit_vld:
  - if bit_in==last_bit: run_len = min(run_len+1, 2^CNT_W-1).
  - else: run_len=1 and last_bit=bit_in.
  - Match when the new run_len >= cfg_len and the polarity of bit_in is enabled in cfg_mode.
  - On match: hit=1 next cycle and evt_cnt+1.
  - If the incremented evt_cnt == cfg_target, go to DONE.
  - Cycles without bit_vld change nothing.
- **DONE**: done=1 for exactly this cycle, then IDLE. bit_vld is ignored.
- **abort**: in FIRST, RUN or DONE, go to IDLE at the next edge. hit and done are not produced for that edge. evt_cnt and run_len hold. abort in IDLE has no effect.
- Overlap: while a run stays at or above cfg_len, every further identical bit is a new event, including after run_len saturates.
- start while busy: ignored, no err.
- Config inputs are sampled only on an accepted start. Later changes have no effect until the next run.

## Timing
- Reset: state=IDLE; busy, hit, done, err = 0; evt_cnt=0; run_len=0; last_bit=0.
- Latency: a bit accepted at edge k gives hit=1 in the cycle following edge k (registered, 1-cycle pulse).
- hit, done and evt_cnt:
  - The final hit and done are high in the same cycle.
  - evt_cnt already shows the incremented value in that cycle.
- busy goes high the cycle after an accepted start. It goes low the cycle after DONE or after the abort edge.
- A new start is accepted the cycle after done drops (back-to-back operation, one idle cycle).
- rst mid-operation forces reset values at the next edge. Nothing is preserved.
- hit, done and err are never high for more than one consecutive cycle, except hit on consecutive matching bits.

## Test plan
- **Basic overlap.** cfg_len=3, mode=3, target=4. Bits 1,1,1,1,0,0,0,0, one per cycle. Expect:
  - hits after bits 3, 4, 7 and 8;
  - evt_cnt goes 1..4;
  - done together with the 4th hit, then busy=0.
- **Polarity filter.** cfg_len=2, mode=1, target=2. Bits 0,0,0,1,1,1. Expect no hits on the 0s, hits after bits 5 and 6, then done.
- **Gapped valid and saturation.** cfg_len=15, mode=2, target=3. Feed 17 zeros with bit_vld toggling every other cycle. Expect:
  - run_len saturates at 15;
  - hits after the 15th, 16th and 17th valid zero only;
  - no activity on invalid cycles.
- **Illegal config.** start with cfg_len=1, then with cfg_mode=0. Expect err pulse each time, busy stays 0, evt_cnt unchanged.
- **Abort mid-run.** cfg_len=3, target=5. After 2 hits, assert abort together with a matching bit. Expect:
  - no hit and no done;
  - IDLE next cycle, with evt_cnt=2 held;
  - a following start clears evt_cnt to 0.
- **Reset and busy behaviour.**
  - rst during RUN: all outputs return to reset values next cycle.
  - start pulsed while busy: ignored, configuration unchanged.
